// File: rtl/tmds_pkg.sv
// Shared constants and helpers for the TMDS channel encoder.
package tmds_pkg;

    localparam int unsigned CNT_W = 5;

    localparam logic [9:0] CTRL_TOKEN0 = 10'h354;
    localparam logic [9:0] CTRL_TOKEN1 = 10'h0AB;
    localparam logic [9:0] CTRL_TOKEN2 = 10'h154;
    localparam logic [9:0] CTRL_TOKEN3 = 10'h2AB;

    typedef logic signed [CNT_W-1:0] disp_t;

    // Control-period character for {c1,c0}.
    function automatic logic [9:0] ctrl_token(input logic [1:0] c);
        logic [9:0] tok;
        case (c)
            2'b01:   tok = CTRL_TOKEN1;
            2'b10:   tok = CTRL_TOKEN2;
            2'b11:   tok = CTRL_TOKEN3;
            default: tok = CTRL_TOKEN0;
        endcase
        return tok;
    endfunction

endpackage

// File: rtl/tmds_popcount8.sv
// Combinational ones count of an 8-bit word.
module tmds_popcount8 (
    input  logic [7:0] data,
    output logic [3:0] count
);

    always_comb begin
        count = '0;
        for (int i = 0; i < 8; i++) begin
            count = count + 4'(data[i]);
        end
    end

endmodule

// File: rtl/tmds_channel_encoder.sv
// Single-channel DVI TMDS 8b/10b encoder, three-stage pipeline.
// Optional disparity monitor outputs when TMDS_ENC_DISP_MON_EN is defined.
module tmds_channel_encoder #(
    parameter int unsigned CNT_W    = tmds_pkg::CNT_W,
    parameter int unsigned PIPE_LAT = 3
) (
    input  logic                    pclk,
    input  logic                    rst_n,
    input  logic                    de,
    input  logic [7:0]              din,
    input  logic                    c0,
    input  logic                    c1,
`ifdef TMDS_ENC_DISP_MON_EN
    output logic signed [CNT_W-1:0] disp,
    output logic                    disp_err,
`endif
    output logic [9:0]              dout
);

    import tmds_pkg::*;

    if (PIPE_LAT != 3) begin : g_lat_chk
        $error("tmds_channel_encoder: PIPE_LAT must be 3");
    end
    if (CNT_W < 5) begin : g_cnt_chk
        $error("tmds_channel_encoder: CNT_W must be at least 5");
    end

    localparam logic signed [CNT_W-1:0] TWO = CNT_W'(2);

    logic [7:0]              din_s0;
    logic                    de_s0;
    logic [1:0]              c_s0;
    logic [3:0]              n1d;
    logic                    xnor_sel;
    logic [8:0]              q_m;
    logic [3:0]              n1q;
    logic [8:0]              q_m_s1;
    logic [3:0]              n1q_s1;
    logic                    de_s1;
    logic [1:0]              c_s1;
    logic signed [CNT_W-1:0] cnt;
    logic signed [CNT_W-1:0] cnt_nxt;
    logic signed [CNT_W-1:0] n1s;
    logic signed [CNT_W-1:0] n0s;
    logic signed [CNT_W-1:0] diff;
    logic signed [CNT_W-1:0] q8x2;
    logic                    cnt_pos;
    logic                    cnt_neg;
    logic [9:0]              dout_nxt;

    tmds_popcount8 u_pop_din (.data(din_s0),   .count(n1d));
    tmds_popcount8 u_pop_qm  (.data(q_m[7:0]), .count(n1q));

    // Stage 0: input capture.
    always_ff @(posedge pclk) begin
        if (!rst_n) begin
            din_s0 <= '0;
            de_s0  <= 1'b0;
            c_s0   <= 2'b00;
        end else begin
            din_s0 <= din;
            de_s0  <= de;
            c_s0   <= {c1, c0};
        end
    end

    // Stage 1: transition-minimised word.
    always_comb begin
        xnor_sel = (n1d > 4'd4) || ((n1d == 4'd4) && !din_s0[0]);
        q_m      = '0;
        q_m[0]   = din_s0[0];
        for (int i = 1; i < 8; i++) begin
            q_m[i] = xnor_sel ? ~(q_m[i-1] ^ din_s0[i]) : (q_m[i-1] ^ din_s0[i]);
        end
        q_m[8] = ~xnor_sel;
    end

    always_ff @(posedge pclk) begin
        if (!rst_n) begin
            q_m_s1 <= '0;
            n1q_s1 <= '0;
            de_s1  <= 1'b0;
            c_s1   <= 2'b00;
        end else begin
            q_m_s1 <= q_m;
            n1q_s1 <= n1q;
            de_s1  <= de_s0;
            c_s1   <= c_s0;
        end
    end

    assign cnt_neg = cnt[CNT_W-1];
    assign cnt_pos = !cnt[CNT_W-1] && (cnt != '0);

    // Stage 2: DC balancing; n1q==n0q is n1q==4 since n0q = 8 - n1q.
    always_comb begin
        n1s      = CNT_W'(n1q_s1);
        n0s      = CNT_W'(4'd8 - n1q_s1);
        diff     = n1s - n0s;
        q8x2     = q_m_s1[8] ? TWO : '0;
        dout_nxt = ctrl_token(c_s1);
        cnt_nxt  = '0;
        if (de_s1) begin
            if ((cnt == '0) || (n1q_s1 == 4'd4)) begin
                dout_nxt = {~q_m_s1[8], q_m_s1[8], q_m_s1[8] ? q_m_s1[7:0] : ~q_m_s1[7:0]};
                cnt_nxt  = q_m_s1[8] ? (cnt + diff) : (cnt - diff);
            end else if ((cnt_pos && (n1q_s1 > 4'd4)) || (cnt_neg && (n1q_s1 < 4'd4))) begin
                dout_nxt = {1'b1, q_m_s1[8], ~q_m_s1[7:0]};
                cnt_nxt  = cnt + q8x2 - diff;
            end else begin
                dout_nxt = {1'b0, q_m_s1[8], q_m_s1[7:0]};
                cnt_nxt  = cnt + diff - (TWO - q8x2);
            end
        end
    end

    always_ff @(posedge pclk) begin
        if (!rst_n) begin
            dout <= CTRL_TOKEN0;
            cnt  <= '0;
        end else begin
            dout <= dout_nxt;
            cnt  <= cnt_nxt;
        end
    end

`ifdef TMDS_ENC_DISP_MON_EN
    localparam logic signed [CNT_W-1:0] DISP_MAX = CNT_W'(8);

    assign disp = cnt;

    // Sticky flag for a running disparity outside the compliant window.
    always_ff @(posedge pclk) begin
        if (!rst_n) begin
            disp_err <= 1'b0;
        end else if (de_s1 && ((cnt_nxt > DISP_MAX) || (cnt_nxt < -DISP_MAX))) begin
            disp_err <= 1'b1;
        end
    end
`endif

endmodule

// File: doc/tmds_channel_encoder.md
Name: tmds_channel_encoder

Overview:
- Single-channel DVI 1.0 TMDS 8b/10b encoder: 8-bit pixel component plus two control bits in, one 10-bit TMDS character out per pclk.
- Transmit-side counterpart of the per-channel decode inside dvi_decoder.
- Three instances (blue/green/red) feed convert_30to15_fifo and the serdes_n_to_1 output path.
- Lets processed pixels from the convolution pipeline be re-encoded instead of passing raw s_data through.

Parameters:
- CNT_W, 5: width of the signed running-disparity counter. Must be ≥5; reaching the value 16 would not fit.
- PIPE_LAT, 3: fixed pipeline latency in pclk cycles. Informational only; RTL asserts PIPE_LAT==3 at elaboration.

Ports:
- pclk  in  1  pixel clock; all logic on rising edge
- rst_n  in  1  synchronous reset, active low
- de  in  1  data enable; 1 = video period, 0 = control period
- din  in  8  pixel component, sampled when de=1
- c0  in  1  control bit 0 (hsync on blue channel), sampled when de=0
- c1  in  1  control bit 1 (vsync on blue channel), sampled when de=0
- dout  out  10  TMDS character, bit 0 transmitted first

Behaviour:
- Reset (rst_n=0 at a pclk edge): all pipeline registers cleared.
  - Delayed de=0 and c=00.
  - dout=10'h354 (control token for c=00).
  - Disparity count cnt=0.
- Reset mid-stream: the character in flight is discarded. The first post-reset output is 10'h354 until the new inputs have propagated.
- Latency: inputs sampled at edge k appear on dout after edge k+3. One character per cycle, no stalls, no handshake.
- Stage 0: register din, de, c0, c1. Compute n1d = popcount(din), 4 bits.
- Stage 1 (transition minimisation):
  - Select XNOR if n1d>4 or (n1d==4 and din[0]==0); otherwise select XOR.
  - q_m[0]=din[0]. For i=1..7, q_m[i]=q_m[i-1] XOR din[i], or XNOR in XNOR mode.
  - q_m[8]=1 for XOR, 0 for XNOR.
  - Register q_m, n1q = popcount(q_m[7:0]), n0q = 8-n1q, plus the delayed de/c.
- Stage 2 (DC balance, output register), when de=1:
  - Case A, cnt==0 or n1q==n0q:
    - dout = {~q_m[8], q_m[8], q_m[8] ? q_m[7:0] : ~q_m[7:0]}.
    - If q_m[8]=1, cnt += n1q-n0q; otherwise cnt += n0q-n1q.
  - Case B, (cnt>0 and n1q>n0q) or (cnt<0 and n0q>n1q):
    - dout = {1, q_m[8], ~q_m[7:0]}.
    - cnt += 2*q_m[8] + n0q - n1q.
  - Case C, otherwise:
    - dout = {0, q_m[8], q_m[7:0]}.
    - cnt += n1q - n0q - 2*(~q_m[8]).
- Stage 2, when de=0: cnt=0 and dout is the control token for {c1,c0}:
  - 00 → 10'h354 (1101010100)
  - 01 → 10'h0AB (0010101011)
  - 10 → 10'h154 (0101010100)
  - 11 → 10'h2AB (1010101011)
- Arithmetic: all disparity math is signed CNT_W bits. Compliant input keeps cnt within [-8,+8], so no saturation is needed.
- de edges: the first video character after control always starts from cnt=0. A de toggling every cycle is legal, and each character is encoded per its own delayed de.

Optional Feature:
- Macro TMDS_ENC_DISP_MON_EN.
- When defined, two extra outputs are added:
  - disp (CNT_W, signed): the registered cnt, aligned with dout.
  - disp_err (1): sticky; set when |cnt| > 8 after any update, cleared only by reset.
- When undefined, neither port exists and no monitor logic is generated.

Decomposition:
- Package tmds_pkg holds:
  - CTRL_TOKEN0..3 (10-bit constants).
  - CNT_W default.
  - Function/typedef for the signed disparity type.
- One natural sub-module: tmds_popcount8, a combinational 8-bit ones count with 4-bit output. Instantiated twice, once in stage 0 and once in stage 1.

Test Plan:
- Reset, then hold rst_n=0 for 4 cycles with de=1, din=8'hA5 → dout=10'h354 throughout and 3 cycles after release until data arrives.
- de=0 with {c1,c0} stepping 00,01,10,11 → dout 10'h354, 10'h0AB, 10'h154, 10'h2AB, each 3 cycles after its input.
- After control, de=1 with din=8'h00 twice → dout 10'h100 (cnt=-8), then 10'h3FF (cnt=+2).
- After control, de=1 with din=8'hFF → dout 10'h200 (cnt=-8). Then de=0 → cnt resets; the next din=8'hFF again gives 10'h200.
- Random 10,000 pixels with a random de pattern, compared against a reference model (TMDS decode of dout must return din) → zero mismatches. With TMDS_ENC_DISP_MON_EN, disp_err stays 0 and |disp| ≤ 8.
- Assert rst_n=0 for one cycle mid-line → cnt=0 and the next 3 outputs are 10'h354, then encoding resumes from cnt=0.
